// File: rtl/spi_dev_fwrite_pkg.sv
// Shared spi_dev constants and types for the fwrite block: command codes,
// header geometry, FSM state encoding and the header byte serializer.
package spi_dev_fwrite_pkg;

    localparam logic [7:0] CMD_GET_DEFAULT = 8'hfa;
    localparam logic [7:0] CMD_PUT_DEFAULT = 8'hfb;
    localparam logic [9:0] HDR_LEN         = 10'd10;
    localparam logic [9:0] MAX_LEN         = 10'd512;
    localparam int         FIFO_DEPTH      = 512;
    localparam int         FIFO_WIDTH      = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_PENDING,
        ST_SEND,
        ST_WAIT_ACK
    } state_t;

    typedef struct packed {
        logic [31:0] file_id;
        logic [31:0] offset;
        logic [9:0]  len;
    } xfer_req_t;

    // Big-endian id, big-endian offset, then the 10-bit length in two bytes.
    function automatic logic [7:0] hdr_byte(input xfer_req_t r, input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd0:    b = r.file_id[31:24];
            4'd1:    b = r.file_id[23:16];
            4'd2:    b = r.file_id[15:8];
            4'd3:    b = r.file_id[7:0];
            4'd4:    b = r.offset[31:24];
            4'd5:    b = r.offset[23:16];
            4'd6:    b = r.offset[15:8];
            4'd7:    b = r.offset[7:0];
            4'd8:    b = {6'b0, r.len[9:8]};
            4'd9:    b = r.len[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_dev_fwrite_if.sv
// Signal bundle between spi_dev_fwrite, the SPI protocol wrapper and the fabric.
// The slave modport is the fwrite block's view; master is the driving side.
interface spi_dev_fwrite_if;

    logic [7:0]  pw_wdata;
    logic        pw_wcmd;
    logic        pw_wstb;
    logic        pw_end;
    logic        pw_req;
    logic        pw_gnt;
    logic [7:0]  pw_rdata;
    logic        pw_rstb;
    logic        pw_irq;
    logic [31:0] req_file_id;
    logic [31:0] req_offset;
    logic [9:0]  req_len;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic        done_valid;
    logic [7:0]  done_status;

    modport slave (
        input  pw_wdata, pw_wcmd, pw_wstb, pw_end, pw_gnt,
        input  req_file_id, req_offset, req_len, req_valid,
        input  wr_data, wr_valid,
        output pw_req, pw_rdata, pw_rstb, pw_irq,
        output req_ready, wr_ready, done_valid, done_status
    );

    modport master (
        output pw_wdata, pw_wcmd, pw_wstb, pw_end, pw_gnt,
        output req_file_id, req_offset, req_len, req_valid,
        output wr_data, wr_valid,
        input  pw_req, pw_rdata, pw_rstb, pw_irq,
        input  req_ready, wr_ready, done_valid, done_status
    );

endinterface

// File: rtl/spi_dev_fwrite_fifo_sync_ram.sv
// First-word-fall-through synchronous FIFO with an occupancy counter.
// Pointers wrap naturally, so DEPTH must be a power of two.
module fifo_sync_ram #(
    parameter  int DEPTH = 512,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [LW-1:0]    level,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic             empty;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign push    = wr_en & ~full;
    assign pop     = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/spi_dev_fwrite.sv
// FPGA-to-ESP32 file write: buffers a payload, raises an IRQ, serves header and
// payload on a GET and completes on the PUT that carries the status byte.
//
//   state       | meaning
//   ------------+-------------------------------------------------------
//   ST_IDLE     | ready for a new request
//   ST_ARMED    | request latched, waiting for len bytes in the FIFO
//   ST_PENDING  | payload complete, IRQ raised, waiting for a granted GET
//   ST_SEND     | streaming header then payload (or draining after gnt loss)
//   ST_WAIT_ACK | waiting for the PUT transaction carrying the status byte
module spi_dev_fwrite
    import spi_dev_fwrite_pkg::*;
#(
    parameter logic [7:0] CMD_GET_BYTE = CMD_GET_DEFAULT,
    parameter logic [7:0] CMD_PUT_BYTE = CMD_PUT_DEFAULT
) (
    input logic             clk,
    input logic             rst,
    spi_dev_fwrite_if.slave bus
);

    state_t    state;
    state_t    state_nx;
    xfer_req_t req_q;
    logic [9:0] len_sat;
    logic [9:0] pay_left;
    logic [9:0] byte_cnt;
    logic [9:0] xfer_total;
    logic       in_xfer;
    logic       cmd_stb_get;
    logic       cmd_stb_put;
    logic       get_active;
    logic       put_active;
    logic       put_live;
    logic       put_done;
    logic       gnt_ok;
    logic       drain;
    logic       emit;
    logic [7:0] emit_byte;
    logic       fifo_pop;
    logic [7:0] fifo_dout;
    logic [9:0] fifo_level;
    logic       fifo_full;
    logic [7:0] stat_q;
    logic       stat_got;
    logic       stat_take;
    logic [7:0] stat_next;
    logic [7:0] rdata_q;
    logic       rstb_q;
    logic       done_valid_q;
    logic [7:0] done_status_q;

    fifo_sync_ram #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(FIFO_WIDTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (bus.wr_valid & ~fifo_full),
        .wr_data(bus.wr_data),
        .rd_en  (fifo_pop),
        .rd_data(fifo_dout),
        .level  (fifo_level),
        .full   (fifo_full)
    );

    assign len_sat    = (bus.req_len > MAX_LEN) ? MAX_LEN : bus.req_len;
    assign gnt_ok     = get_active & bus.pw_gnt;
    assign in_xfer    = (state == ST_PENDING) || (state == ST_SEND);
    assign xfer_total = HDR_LEN + (in_xfer ? req_q.len : 10'd0);
    assign put_live   = put_active | cmd_stb_put;
    assign put_done   = (state == ST_WAIT_ACK) & put_live & bus.pw_end;

    // A GET outside a live transfer returns an all-zero header (len 0).
    assign emit_byte = (byte_cnt >= HDR_LEN) ? fifo_dout
                     : (in_xfer ? hdr_byte(req_q, byte_cnt[3:0]) : 8'h00);

    // Status is the first data byte after the PUT command; it may arrive
    // while the command strobe is still in its registered stage.
    assign stat_take = put_live & bus.pw_wstb & ~bus.pw_wcmd & (cmd_stb_put | ~stat_got);
    assign stat_next = stat_take   ? bus.pw_wdata
                     : cmd_stb_put ? 8'hff : stat_q;

    always_comb begin
        state_nx = state;
        emit     = 1'b0;
        fifo_pop = 1'b0;
        case (state)
            ST_IDLE: begin
                emit = gnt_ok & (byte_cnt < HDR_LEN);
                if (bus.req_valid) state_nx = ST_ARMED;
            end
            ST_ARMED: begin
                emit = gnt_ok & (byte_cnt < HDR_LEN);
                if (fifo_level >= req_q.len) state_nx = ST_PENDING;
            end
            ST_PENDING: begin
                if (gnt_ok && byte_cnt == 10'd0) begin
                    emit     = 1'b1;
                    state_nx = ST_SEND;
                end
            end
            ST_SEND: begin
                if (gnt_ok && !drain) begin
                    emit     = 1'b1;
                    fifo_pop = (byte_cnt >= HDR_LEN);
                    if (byte_cnt == xfer_total - 10'd1) state_nx = ST_WAIT_ACK;
                end else begin
                    fifo_pop = (pay_left != 10'd0);
                    if (pay_left <= 10'd1) state_nx = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                emit = gnt_ok & (byte_cnt < HDR_LEN);
                if (put_done) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            req_q         <= '0;
            pay_left      <= '0;
            drain         <= 1'b0;
            cmd_stb_get   <= 1'b0;
            cmd_stb_put   <= 1'b0;
            get_active    <= 1'b0;
            put_active    <= 1'b0;
            stat_q        <= 8'hff;
            stat_got      <= 1'b0;
            rdata_q       <= 8'h00;
            rstb_q        <= 1'b0;
            done_valid_q  <= 1'b0;
            done_status_q <= 8'h00;
        end else begin
            state       <= state_nx;
            drain       <= (state == ST_SEND) && (state_nx == ST_SEND) && (drain || !gnt_ok);
            cmd_stb_get <= bus.pw_wstb & bus.pw_wcmd & (bus.pw_wdata == CMD_GET_BYTE);
            cmd_stb_put <= bus.pw_wstb & bus.pw_wcmd & (bus.pw_wdata == CMD_PUT_BYTE);
            if (bus.pw_end)       get_active <= 1'b0;
            else if (cmd_stb_get) get_active <= 1'b1;
            if (bus.pw_end)       put_active <= 1'b0;
            else if (cmd_stb_put) put_active <= 1'b1;
            if (state == ST_IDLE && bus.req_valid) begin
                req_q    <= '{file_id: bus.req_file_id, offset: bus.req_offset, len: len_sat};
                pay_left <= len_sat;
            end else if (fifo_pop && pay_left != 10'd0) begin
                pay_left <= pay_left - 10'd1;
            end
            stat_q   <= stat_next;
            stat_got <= stat_take | (stat_got & ~cmd_stb_put);
            rstb_q   <= emit;
            if (emit) rdata_q <= emit_byte;
            done_valid_q <= put_done;
            if (put_done) done_status_q <= stat_next;
        end
    end

    // Byte index restarts whenever the wrapper withdraws the grant.
    always_ff @(posedge clk) begin
        if (rst || !bus.pw_gnt) byte_cnt <= '0;
        else if (emit)          byte_cnt <= byte_cnt + 10'd1;
    end

    assign bus.pw_req      = get_active;
    assign bus.pw_rdata    = rdata_q;
    assign bus.pw_rstb     = rstb_q;
    assign bus.pw_irq      = (state == ST_PENDING);
    assign bus.req_ready   = (state == ST_IDLE);
    assign bus.wr_ready    = ~fifo_full;
    assign bus.done_valid  = done_valid_q;
    assign bus.done_status = done_status_q;

endmodule

// File: doc/spi_dev_fwrite.md
# spi_dev_fwrite

Lets the FPGA push a block of up to 512 bytes to a file held by the ESP32. It is the write-direction counterpart of the fread block and sits on the same SPI protocol wrapper. The fabric posts a request and streams payload bytes into a local 512-byte FIFO. Once the payload is complete, the block raises an IRQ. The ESP32 then pulls header and payload with a GET command and acknowledges with a status byte using a PUT command.

## Interface
Parameters:
- CMD_GET_BYTE, 8'hfa, command byte: ESP32 reads header plus payload
- CMD_PUT_BYTE, 8'hfb, command byte: ESP32 writes completion status

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pw_wdata  in  8  wrapper write byte
- pw_wcmd  in  1  byte is a command byte
- pw_wstb  in  1  write byte strobe
- pw_end  in  1  end-of-transaction pulse
- pw_req  out  1  request for the response path
- pw_gnt  in  1  response path granted
- pw_rdata  out  8  response byte
- pw_rstb  out  1  response byte strobe
- pw_irq  out  1  request pending toward the ESP32
- req_file_id  in  32  target file ID
- req_offset  in  32  byte offset in the file
- req_len  in  10  payload length, 1..512
- req_valid  in  1  request valid
- req_ready  out  1  request accepted
- wr_data  in  8  payload byte
- wr_valid  in  1  payload byte valid
- wr_ready  out  1  FIFO not full
- done_valid  out  1  one-cycle completion pulse
- done_status  out  8  status byte from the ESP32, held until the next completion

## Operation
- Command decode:
  - cmd_stb_get/cmd_stb_put are registered from pw_wstb & pw_wcmd & (pw_wdata == code).
  - The matching active flag sets on the strobe and clears on pw_end.
  - pw_req = get_active.
- FSM states: IDLE, ARMED, PENDING, SEND, WAIT_ACK.
  - IDLE: req_ready=1. req_valid latches file_id, offset and len, and moves to ARMED.
  - ARMED: moves to PENDING when the FIFO level >= len.
  - PENDING: pw_irq=1. A GET grant moves to SEND.
  - SEND: pushes 10 header bytes, then len payload bytes popped from the FIFO. Moves to WAIT_ACK after the last push.
  - WAIT_ACK: the PUT transaction's pw_end pulses done_valid, updates done_status, and returns to IDLE.
- Header byte order: file_id[31:24..7:0], then offset[31:24..7:0], then {6'b0, len[9:8]}, then len[7:0].
- FIFO:
  - 512 deep, first-word-fall-through.
  - Write when wr_valid & wr_ready.
  - Level counter is 10 bits, range 0..512.
  - Writes are accepted in every state.
- Boundary conditions:
  - GET outside PENDING/SEND: sends 10 zero bytes (len 0), no pop, no state change.
  - pw_gnt drops during SEND: remaining payload bytes are popped and discarded at 1 per cycle, then WAIT_ACK.
  - PUT outside WAIT_ACK: ignored.
  - Status byte is the first data byte after the PUT command. Later bytes are ignored. If none arrives, status = 8'hff.
  - req_len == 0: header only, no payload. Values > 512 saturate to 512.
  - Simultaneous FIFO push and pop: level unchanged.
  - rst mid-operation: FSM to IDLE, FIFO emptied, the in-flight transfer is lost.
- Reset values:
  - pw_req=0, pw_rstb=0, pw_irq=0, req_ready=1, done_valid=0.
  - done_status=8'h00, wr_ready=1, pw_rdata=8'h00.

## Timing
- Command active is high 2 cycles after the command pw_wstb.
- pw_rdata/pw_rstb are registered. The first pw_rstb comes the cycle after pw_gnt is first sampled high.
- After that, one byte every cycle, 10+len consecutive strobes with no gaps, while pw_gnt stays high.
- The wrapper response buffer holds ≥522 bytes, so no backpressure is applied.
- The byte counter resets whenever pw_gnt=0.
- FIFO pop is concurrent with the push of the corresponding payload byte.
- ARMED→PENDING: 1 cycle after the level condition holds.
- req_ready drops the cycle after acceptance.
- done_valid is asserted the cycle after the PUT pw_end.

## Structure
- Shared package (existing spi_dev constants): default command codes, header length 10, max payload 512.
- One sub-module: fifo_sync_ram (DEPTH 512, WIDTH 8). The level counter is local to this block.

## Test plan
- Basic transfer:
  - Stimulus: request id=0x11223344, off=0x00000100, len=4, then push AA BB CC DD; GET; then PUT with byte 00.
  - Required: irq rises only after the 4th byte. Strobes give 11 22 33 44 00 00 01 00 00 04 AA BB CC DD. done_valid pulses once with done_status=00, req_ready returns to 1.
- Full 512-byte transfer:
  - Stimulus: 512 bytes pushed, len=512.
  - Required: wr_ready=0 at level 512. Header ends 02 00. 522 consecutive strobes, FIFO empty afterwards.
- Spurious GET:
  - Stimulus: GET while IDLE.
  - Required: 10 zero bytes, FSM stays IDLE, no irq.
- Early gnt loss:
  - Stimulus: gnt dropped after 5 strobes with len=8.
  - Required: FIFO drained to 0, WAIT_ACK. PUT with no data gives done_status=ff.
- Reset mid-transfer:
  - Stimulus: rst in SEND.
  - Required: all outputs at reset values next cycle, level 0, and a fresh request then works.
